// File: rtl/spi_master_xfer.sv
// Mode-0 SPI master: framed 1..MAX_BYTES byte transfer, MSB first.
// /CS held low across the frame; MISO bytes returned left-aligned.
module spi_master_xfer #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 3,
  parameter int CS_SETUP  = 4,
  parameter int BYTE_GAP  = 8,
  parameter int CS_HOLD   = 4,
  localparam int FW       = 8 * MAX_BYTES
) (
  input  logic          sysClk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    num_bytes,
  input  logic [FW-1:0] tx_frame,
  output logic          busy,
  output logic          done,
  output logic [FW-1:0] rx_frame,
  output logic          spiClk,
  output logic          cs,
  output logic          mosi,
  input  logic          miso
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOW,
    S_HIGH,
    S_GAP,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    byte_q, byte_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    n_q, n_d;
  logic [FW-1:0] tx_q, tx_d;
  logic [FW-1:0] rx_sh_q, rx_sh_d;
  logic [FW-1:0] rx_frame_q, rx_frame_d;
  logic          cs_q, cs_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          legal;
  logic [FW-1:0] rx_align;

  assign legal = (num_bytes != 2'd0) &&
                 (int'(num_bytes) <= MAX_BYTES);

  // Short frames fill only the low bytes of the shifter.
  assign rx_align = rx_sh_q << (8 * (MAX_BYTES - int'(n_q)));

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      byte_q     <= '0;
      bit_q      <= '0;
      n_q        <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_frame_q <= '0;
      cs_q       <= 1'b1;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_q     <= byte_d;
      bit_q      <= bit_d;
      n_q        <= n_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_frame_q <= rx_frame_d;
      cs_q       <= cs_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_d     = byte_q;
    bit_d      = bit_q;
    n_d        = n_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_frame_d = rx_frame_q;
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // First IDLE cycle after HOLD is the done cycle; busy drops after it.
        busy_d = 1'b0;
        if (start && !busy_q && legal) begin
          n_d     = num_bytes;
          tx_d    = tx_frame;
          rx_sh_d = '0;
          byte_d  = '0;
          bit_d   = 3'd7;
          cnt_d   = '0;
          cs_d    = 1'b0;
          mosi_d  = tx_frame[FW-1];
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == CW'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_LOW: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[FW-2:0], miso};
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HIGH: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 1'b1;
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[FW-2];
            state_d = S_LOW;
          end else if (byte_q != n_q - 2'd1) begin
            byte_d  = byte_q + 1'b1;
            bit_d   = 3'd7;
            tx_d    = tx_q << 1;
            mosi_d  = tx_q[FW-2];
            state_d = S_GAP;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == CW'(BYTE_GAP - 1)) begin
          cnt_d   = '0;
          state_d = S_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        if (cnt_q == CW'(CS_HOLD - 1)) begin
          cnt_d      = '0;
          cs_d       = 1'b1;
          done_d     = 1'b1;
          rx_frame_d = rx_align;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rx_frame = rx_frame_q;
  assign spiClk   = sclk_q;
  assign cs       = cs_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_xfer.sv
// Directed bench for spi_master_xfer with a small register-read slave
// model and an optional MOSI->MISO loopback.
module tb_spi_master_xfer;

  logic        sysClk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  num_bytes;
  logic [23:0] tx_frame;
  logic        busy;
  logic        done;
  logic [23:0] rx_frame;
  logic        spiClk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic        lb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sysClk = ~sysClk;

  spi_master_xfer dut (
    .sysClk    (sysClk),
    .reset     (reset),
    .start     (start),
    .num_bytes (num_bytes),
    .tx_frame  (tx_frame),
    .busy      (busy),
    .done      (done),
    .rx_frame  (rx_frame),
    .spiClk    (spiClk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso)
  );

  // Slave model: byte0 opcode, byte1 register address, byte2 read data.
  logic       s_pc = 1'b0;
  logic [4:0] s_cnt = '0;
  logic [7:0] s_in = '0;
  logic [7:0] s_op = '0;
  logic [7:0] s_out = '0;
  logic       s_miso = 1'b0;

  function automatic logic [7:0] reg_val(input logic [7:0] a);
    case (a)
      8'h0A:   return 8'h28;
      8'h0F:   return 8'hF9;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge sysClk) begin
    if (cs) begin
      s_cnt  <= '0;
      s_in   <= '0;
      s_op   <= '0;
      s_miso <= 1'b0;
    end else begin
      if (spiClk && !s_pc) begin
        s_in  <= {s_in[6:0], mosi};
        s_cnt <= s_cnt + 1'b1;
        if (s_cnt == 5'd7)
          s_op <= {s_in[6:0], mosi};
        if (s_cnt == 5'd15)
          s_out <= (s_op == 8'h41) ?
                   reg_val({s_in[6:0], mosi}) : 8'h00;
      end
      if (!spiClk && s_pc && s_cnt >= 5'd16) begin
        s_miso <= s_out[7];
        s_out  <= {s_out[6:0], 1'b0};
      end
    end
    s_pc <= spiClk;
  end

  assign miso = lb ? mosi : s_miso;

  // Frame observation
  int          o_len, o_rises, o_hibad, o_lobad, o_gaps, o_dw;
  bit          o_csok, o_mok;
  logic [23:0] o_cap;

  task automatic do_frame(input logic [1:0] n,
                          input logic [23:0] tx);
    logic pc, pm;
    int hr, lr;
    @(negedge sysClk);
    num_bytes = n;
    tx_frame  = tx;
    start     = 1'b1;
    o_len = 0; o_rises = 0; o_hibad = 0;
    o_lobad = 0; o_gaps = 0; o_dw = 0;
    o_csok = 1; o_mok = 1; o_cap = '0;
    pc = 1'b0; pm = 1'b0; hr = 0; lr = 0;
    do begin
      @(negedge sysClk);
      start = 1'b0;
      o_len++;
      if (!done) begin
        if (cs !== 1'b0) o_csok = 0;
        if (spiClk && !pc) begin
          o_rises++;
          if (o_len > 1 && mosi !== pm) o_mok = 0;
          o_cap = {o_cap[22:0], mosi};
          if (o_rises == 1) begin
            if (lr != 8) o_lobad++;
          end else if (lr == 12) begin
            o_gaps++;
          end else if (lr != 4) begin
            o_lobad++;
          end
          lr = 0;
        end
        if (!spiClk && pc) begin
          if (hr != 4) o_hibad++;
          hr = 0;
        end
        if (spiClk) hr++;
        else lr++;
        pc = spiClk;
        pm = mosi;
      end
    end while (!done && o_len < 1000);
    while (done && o_dw < 5) begin
      o_dw++;
      @(negedge sysClk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; num_bytes = '0;
    tx_frame = '0; lb = 1'b0;
    repeat (3) @(negedge sysClk);
    reset = 1'b0;
    @(negedge sysClk);
    n_checks++;
    if (cs !== 1'b1) begin
      n_errors++; $display("FAIL reset_cs: got %b want 1", cs);
    end
    n_checks++;
    if (spiClk !== 1'b0) begin
      n_errors++; $display("FAIL reset_sclk: got %b want 0", spiClk);
    end
    n_checks++;
    if (mosi !== 1'b0) begin
      n_errors++; $display("FAIL reset_mosi: got %b want 0", mosi);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_checks++;
    if (done !== 1'b0) begin
      n_errors++; $display("FAIL reset_done: got %b want 0", done);
    end
    n_checks++;
    if (rx_frame !== 24'h0) begin
      n_errors++; $display("FAIL reset_rx: got %h want 0", rx_frame);
    end
  endtask

  task automatic test_slave_iocon;
    lb = 1'b0;
    do_frame(2'd3, 24'h410A00);
    n_checks++;
    if (rx_frame !== 24'h000028) begin
      n_errors++;
      $display("FAIL iocon_rx: got %h want 000028", rx_frame);
    end
    n_checks++;
    if (o_rises !== 24) begin
      n_errors++; $display("FAIL iocon_rises: got %0d want 24", o_rises);
    end
    n_checks++;
    if (o_csok !== 1'b1) begin
      n_errors++; $display("FAIL iocon_cs_low: got %b want 1", o_csok);
    end
    n_checks++;
    if (o_len !== 217) begin
      n_errors++; $display("FAIL iocon_len: got %0d want 217", o_len);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL iocon_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_slave_reg0f;
    lb = 1'b0;
    do_frame(2'd3, 24'h410F00);
    n_checks++;
    if (rx_frame !== 24'h0000F9) begin
      n_errors++;
      $display("FAIL reg0f_rx: got %h want 0000F9", rx_frame);
    end
    n_checks++;
    if (o_dw !== 1) begin
      n_errors++; $display("FAIL reg0f_done_w: got %0d want 1", o_dw);
    end
    n_checks++;
    if (o_cap !== 24'h410F00) begin
      n_errors++; $display("FAIL reg0f_mosi: got %h want 410F00", o_cap);
    end
    n_checks++;
    if (o_gaps !== 2) begin
      n_errors++; $display("FAIL reg0f_gaps: got %0d want 2", o_gaps);
    end
    n_checks++;
    if (o_hibad !== 0) begin
      n_errors++; $display("FAIL reg0f_high: got %0d want 0", o_hibad);
    end
    n_checks++;
    if (o_lobad !== 0) begin
      n_errors++; $display("FAIL reg0f_low: got %0d want 0", o_lobad);
    end
  endtask

  task automatic test_loopback;
    lb = 1'b1;
    do_frame(2'd1, 24'hA53C77);
    n_checks++;
    if (rx_frame !== 24'hA50000) begin
      n_errors++; $display("FAIL lb_rx: got %h want A50000", rx_frame);
    end
    n_checks++;
    if (o_mok !== 1'b1) begin
      n_errors++; $display("FAIL lb_mosi_stable: got %b want 1", o_mok);
    end
    n_checks++;
    if (o_rises !== 8) begin
      n_errors++; $display("FAIL lb_rises: got %0d want 8", o_rises);
    end
    n_checks++;
    if (o_len !== 73) begin
      n_errors++; $display("FAIL lb_len: got %0d want 73", o_len);
    end
    lb = 1'b0;
  endtask

  task automatic test_ignore;
    int len, ndone, ncs, nbusy;
    lb = 1'b1;
    @(negedge sysClk);
    num_bytes = 2'd1; tx_frame = 24'h3C0000; start = 1'b1;
    len = 0;
    do begin
      @(negedge sysClk);
      start = 1'b0;
      len++;
      if (len == 10) begin
        num_bytes = 2'd3; tx_frame = 24'hFFFFFF; start = 1'b1;
      end
    end while (!done && len < 1000);
    n_checks++;
    if (len !== 73) begin
      n_errors++; $display("FAIL busy_start_len: got %0d want 73", len);
    end
    n_checks++;
    if (rx_frame !== 24'h3C0000) begin
      n_errors++;
      $display("FAIL busy_start_rx: got %h want 3C0000", rx_frame);
    end
    num_bytes = 2'd1; start = 1'b1;
    @(negedge sysClk);
    start = 1'b0;
    ndone = 0; ncs = 0;
    repeat (100) begin
      if (done) ndone++;
      if (!cs) ncs++;
      @(negedge sysClk);
    end
    n_checks++;
    if (ndone !== 0 || ncs !== 0) begin
      n_errors++;
      $display("FAIL done_start: got done=%0d cs_low=%0d want 0/0",
               ndone, ncs);
    end
    num_bytes = 2'd0; start = 1'b1;
    @(negedge sysClk);
    start = 1'b0;
    ncs = 0; nbusy = 0;
    repeat (50) begin
      if (!cs) ncs++;
      if (busy || done) nbusy++;
      @(negedge sysClk);
    end
    n_checks++;
    if (ncs !== 0 || nbusy !== 0) begin
      n_errors++;
      $display("FAIL n0_start: got cs_low=%0d busy=%0d want 0/0",
               ncs, nbusy);
    end
    lb = 1'b0;
  endtask

  task automatic test_reset_mid;
    int ndone;
    lb = 1'b0;
    @(negedge sysClk);
    num_bytes = 2'd3; tx_frame = 24'h410A00; start = 1'b1;
    @(negedge sysClk);
    start = 1'b0;
    repeat (99) @(negedge sysClk);
    n_checks++;
    if (cs !== 1'b0) begin
      n_errors++; $display("FAIL mid_cs_before: got %b want 0", cs);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (cs !== 1'b1 || spiClk !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_async: got cs=%b sclk=%b busy=%b want 1/0/0",
               cs, spiClk, busy);
    end
    @(negedge sysClk);
    reset = 1'b0;
    ndone = 0;
    repeat (200) begin
      if (done || !cs) ndone++;
      @(negedge sysClk);
    end
    n_checks++;
    if (ndone !== 0) begin
      n_errors++; $display("FAIL mid_no_done: got %0d want 0", ndone);
    end
    lb = 1'b1;
    do_frame(2'd2, 24'h5AC3EE);
    n_checks++;
    if (rx_frame !== 24'h5AC300) begin
      n_errors++; $display("FAIL mid_next_rx: got %h want 5AC300", rx_frame);
    end
    n_checks++;
    if (o_len !== 145) begin
      n_errors++; $display("FAIL mid_next_len: got %0d want 145", o_len);
    end
    lb = 1'b0;
  endtask

  initial begin
    test_reset();
    test_slave_iocon();
    test_slave_reg0f();
    test_loopback();
    test_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
